mem_arbiter: RTL and testbench

Arbiter and sequencer for the single-port unified instruction/data memory of the LAPI DOpaCA LAMBA core. It shares the memory between the IF-stage fetch port and the MEM-stage load/store port and runs each access over a fixed latency. While any access is outstanding it raises `stall_pipeline`, which feeds the control unit and the pipeline registers.

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter_latency_counter.sv | 30 +++
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the unified-memory arbiter.
// State encodings match ARB_IDLE / ARB_BUSY_IF / ARB_BUSY_DM in lapido_defs.v.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_DM = 2'd2
  } arb_state_t;

  // The latency counter needs at least one bit even when MEM_LATENCY is 1.
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and RAM port of the unified-memory arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  // Handshake: a requester raises req with stable addr/data and holds it until
  // ack. ack is a one-cycle pulse, and rdata is valid in that same cycle. Req may
  // still be high during the ack cycle; the arbiter ignores it for that cycle.
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_ack;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  dm_ack;

  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic                  stall_pipeline;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack,
    output ram_en, ram_we, ram_addr, ram_wdata, stall_pipeline
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack,
    input  ram_en, ram_we, ram_addr, ram_wdata, stall_pipeline
  );

endinterface

// File: rtl/mem_arbiter_latency_counter.sv
// Loadable down-counter that times one RAM access; zero marks the last busy cycle.
module mem_latency_counter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int W = cnt_width(MEM_LATENCY);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(MEM_LATENCY - 1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one single-port RAM between instruction fetch and
// load/store. Data wins ties because it belongs to the older instruction.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus,
  output arb_state_t     dbg_state
);

  arb_state_t            state;
  arb_state_t            state_nxt;
  logic                  grant_if;
  logic                  grant_dm;
  logic                  done;
  logic                  cnt_zero;

  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  lat_we;

  logic                  if_ack_q;
  logic                  dm_ack_q;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] dm_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  // A port whose ack is showing is still dropping req, so it is not eligible.
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_dm  = 1'b0;
    done      = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (bus.dm_req && !dm_ack_q) begin
          grant_dm  = 1'b1;
          state_nxt = ARB_BUSY_DM;
        end else if (bus.if_req && !if_ack_q) begin
          grant_if  = 1'b1;
          state_nxt = ARB_BUSY_IF;
        end
      end
      ARB_BUSY_IF, ARB_BUSY_DM: begin
        if (cnt_zero) begin
          done      = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  mem_latency_counter #(.MEM_LATENCY(MEM_LATENCY)) u_lat_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (grant_if | grant_dm),
    .dec  (state != ARB_IDLE),
    .zero (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
    end else if (grant_dm) begin
      lat_addr  <= bus.dm_addr;
      lat_wdata <= bus.dm_wdata;
      lat_we    <= bus.dm_we;
    end else if (grant_if) begin
      lat_addr  <= bus.if_addr;
    end
  end

  // Stores acknowledge without disturbing the last load result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if_ack_q <= done && (state == ARB_BUSY_IF);
      dm_ack_q <= done && (state == ARB_BUSY_DM);
      if (done && (state == ARB_BUSY_IF))            if_rdata_q <= bus.ram_rdata;
      if (done && (state == ARB_BUSY_DM) && !lat_we) dm_rdata_q <= bus.ram_rdata;
    end
  end

  assign bus.ram_en         = (state != ARB_IDLE);
  assign bus.ram_we         = (state == ARB_BUSY_DM) && lat_we;
  assign bus.ram_addr       = lat_addr;
  assign bus.ram_wdata      = lat_wdata;
  assign bus.if_ack         = if_ack_q;
  assign bus.dm_ack         = dm_ack_q;
  assign bus.if_rdata       = if_rdata_q;
  assign bus.dm_rdata       = dm_rdata_q;
  assign bus.stall_pipeline = (bus.if_req & ~if_ack_q) | (bus.dm_req & ~dm_ack_q);
  assign dbg_state          = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter at MEM_LATENCY 1, 2 and 3 side by side: directed
// literal cases, then random fetch/load/store traffic against a timestamp model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  // ---------------- clock ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int lat,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s lat=%0d t=%0t actual=%h required=%h", name, lat, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // RAM power-up contents; word 0x10 holds the instruction used by the fetch case.
  function automatic logic [31:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {a, ~a, a ^ 8'h3C, 8'h5A};
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_lat
    localparam int L = gi + 1;

    logic       rst;
    logic       done_i;
    arb_state_t dbg;

    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg)
    );

    // ---------------- RAM ----------------
    logic [31:0] ram_mem [256];
    bit          ram_wr  [256];

    assign bus.ram_rdata = ram_wr[bus.ram_addr[7:0]] ? ram_mem[bus.ram_addr[7:0]]
                                                      : init_val(bus.ram_addr[7:0]);

    always @(posedge clk) begin
      if (bus.ram_en && bus.ram_we) begin
        ram_mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
        ram_wr[bus.ram_addr[7:0]]  <= 1'b1;
      end
    end

    // ---------------- reference model + compare ----------------
    // Each grant at cycle t occupies the RAM in cycles t+1..t+L, acks in t+L+1,
    // and the arbiter may grant again (other port only) in the ack cycle.
    initial begin : model
      int          cyc, t_g, ack_c, owner;
      logic [31:0] l_addr, l_wd, pend, e_ifr, e_dmr;
      logic        l_we, busy, e_ifa, e_dma;
      logic [31:0] ref_mem [256];
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
      cyc = 0; t_g = -100; ack_c = -100; owner = 0;
      l_addr = '0; l_wd = '0; l_we = 1'b0; pend = '0; e_ifr = '0; e_dmr = '0;
      forever begin
        @(negedge clk);
        if (rst) begin
          t_g = -100; ack_c = -100; owner = 0;
          l_addr = '0; l_wd = '0; l_we = 1'b0; e_ifr = '0; e_dmr = '0;
          check("m_rst_state", L, 32'(dbg), 32'(ARB_IDLE));
          check("m_rst_ram_ctl", L, {30'b0, bus.ram_en, bus.ram_we}, 32'h0);
          check("m_rst_acks", L, {30'b0, bus.if_ack, bus.dm_ack}, 32'h0);
          check("m_rst_ram_addr", L, bus.ram_addr, 32'h0);
          check("m_rst_ram_wdata", L, bus.ram_wdata, 32'h0);
          check("m_rst_if_rdata", L, bus.if_rdata, 32'h0);
          check("m_rst_dm_rdata", L, bus.dm_rdata, 32'h0);
        end else begin
          busy  = (owner != 0) && (cyc >= t_g + 1) && (cyc <= t_g + L);
          e_ifa = (owner == 1) && (cyc == ack_c);
          e_dma = (owner == 2) && (cyc == ack_c);
          if (e_ifa) e_ifr = pend;
          if (e_dma && !l_we) e_dmr = pend;
          check("m_ram_en", L, 32'(bus.ram_en), 32'(busy));
          check("m_ram_we", L, 32'(bus.ram_we), 32'(busy && owner == 2 && l_we));
          check("m_if_ack", L, 32'(bus.if_ack), 32'(e_ifa));
          check("m_dm_ack", L, 32'(bus.dm_ack), 32'(e_dma));
          check("m_if_rdata", L, bus.if_rdata, e_ifr);
          check("m_dm_rdata", L, bus.dm_rdata, e_dmr);
          check("m_stall", L, 32'(bus.stall_pipeline),
                32'((bus.if_req && !e_ifa) || (bus.dm_req && !e_dma)));
          if (busy) check("m_ram_addr", L, bus.ram_addr, l_addr);
          if (busy && owner == 2 && l_we) check("m_ram_wdata", L, bus.ram_wdata, l_wd);
          if ((owner == 0) || (cyc >= t_g + L + 1)) begin
            if (bus.dm_req && !e_dma) begin
              owner = 2; t_g = cyc; ack_c = cyc + L + 1;
              l_addr = bus.dm_addr; l_we = bus.dm_we; l_wd = bus.dm_wdata;
              if (l_we) ref_mem[l_addr[7:0]] = l_wd;
              else      pend = ref_mem[l_addr[7:0]];
            end else if (bus.if_req && !e_ifa) begin
              owner = 1; t_g = cyc; ack_c = cyc + L + 1;
              l_addr = bus.if_addr;
              pend = ref_mem[l_addr[7:0]];
            end
          end
          cyc++;
        end
      end
    end

    // ---------------- stimulus with literal expectations ----------------
    initial begin : stim
      logic if_ack_s, dm_ack_s;
      done_i = 1'b0;
      rst = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_state", L, 32'(dbg), 32'(ARB_IDLE));
      check("reset_ram_en", L, 32'(bus.ram_en), 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      step(); step();

      // single fetch of 0xDEADBEEF at 0x10; req held through the ack cycle
      bus.if_req = 1'b1; bus.if_addr = 32'h10;
      for (int k = 0; k <= L + 1; k++) begin
        @(negedge clk);
        check("fetch_ram_en", L, 32'(bus.ram_en), 32'(k >= 1 && k <= L));
        check("fetch_if_ack", L, 32'(bus.if_ack), 32'(k == L + 1));
        check("fetch_stall", L, 32'(bus.stall_pipeline), 32'(k <= L));
        if (k == 1) check("fetch_ram_addr", L, bus.ram_addr, 32'h10);
        if (k == L + 1) check("fetch_rdata", L, bus.if_rdata, 32'hDEADBEEF);
        step();
      end
      bus.if_req = 1'b0;
      @(negedge clk);
      check("held_req_no_refetch", L, 32'(bus.ram_en), 32'h0);
      step();

      // collision: load at 0x20 wins, fetch at 0x33 granted in the dm_ack cycle
      bus.if_req = 1'b1; bus.if_addr = 32'h33;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h20;
      for (int k = 0; k <= 2 * L + 2; k++) begin
        @(negedge clk);
        check("coll_ram_en", L, 32'(bus.ram_en),
              32'((k >= 1 && k <= L) || (k >= L + 2 && k <= 2 * L + 1)));
        check("coll_dm_ack", L, 32'(bus.dm_ack), 32'(k == L + 1));
        check("coll_if_ack", L, 32'(bus.if_ack), 32'(k == 2 * L + 2));
        if (k == 1)         check("coll_addr_dm", L, bus.ram_addr, 32'h20);
        if (k == L + 2)     check("coll_addr_if", L, bus.ram_addr, 32'h33);
        if (k == L + 1)     check("coll_dm_rdata", L, bus.dm_rdata, 32'h20DF1C5A);
        if (k == 2 * L + 2) check("coll_if_rdata", L, bus.if_rdata, 32'h33CC0F5A);
        step();
        if (k == L + 1) bus.dm_req = 1'b0;
      end
      bus.if_req = 1'b0;
      step();

      // store 0x12345678 to 0x40; dm_rdata keeps the earlier load value
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h40; bus.dm_wdata = 32'h12345678;
      for (int k = 0; k <= L + 1; k++) begin
        @(negedge clk);
        check("store_ram_we", L, 32'(bus.ram_we), 32'(k >= 1 && k <= L));
        check("store_dm_ack", L, 32'(bus.dm_ack), 32'(k == L + 1));
        if (k == 1)     check("store_wdata", L, bus.ram_wdata, 32'h12345678);
        if (k == L + 1) check("store_rdata_kept", L, bus.dm_rdata, 32'h20DF1C5A);
        step();
      end
      bus.dm_req = 1'b0; bus.dm_we = 1'b0;
      step();

      // load back the stored word
      bus.dm_req = 1'b1; bus.dm_addr = 32'h40;
      for (int k = 0; k <= L + 1; k++) begin
        @(negedge clk);
        check("reload_dm_ack", L, 32'(bus.dm_ack), 32'(k == L + 1));
        if (k == L + 1) check("reload_rdata", L, bus.dm_rdata, 32'h12345678);
        step();
      end
      bus.dm_req = 1'b0;
      step();

      // reset in the middle of a load: abort, no ack, outputs cleared
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h50;
      step();
      @(negedge clk);
      check("rst_mid_busy", L, 32'(dbg), 32'(ARB_BUSY_DM));
      #1 rst = 1'b1; bus.dm_req = 1'b0;
      #1;
      check("rst_abort_state", L, 32'(dbg), 32'(ARB_IDLE));
      check("rst_abort_ram_en", L, 32'(bus.ram_en), 32'h0);
      check("rst_abort_dm_ack", L, 32'(bus.dm_ack), 32'h0);
      check("rst_abort_rdata", L, bus.dm_rdata, 32'h0);
      check("rst_abort_addr", L, bus.ram_addr, 32'h0);
      step(); step();
      rst = 1'b0;
      for (int k = 0; k < L + 3; k++) begin
        @(negedge clk);
        check("rst_no_late_ack", L, 32'(bus.dm_ack), 32'h0);
      end
      step();

      // random traffic; each requester holds req through its ack cycle
      for (int c = 0; c < 600; c++) begin
        @(negedge clk);
        if_ack_s = bus.if_ack;
        dm_ack_s = bus.dm_ack;
        @(posedge clk); #1;
        if (bus.if_req) begin
          if (if_ack_s) bus.if_req = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          bus.if_req  = 1'b1;
          bus.if_addr = 32'($urandom_range(0, 255));
        end
        if (bus.dm_req) begin
          if (dm_ack_s) bus.dm_req = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          bus.dm_req   = 1'b1;
          bus.dm_we    = 1'($urandom_range(0, 1));
          bus.dm_addr  = 32'($urandom_range(0, 255));
          bus.dm_wdata = $urandom;
        end
      end
      done_i = 1'b1;
    end
  end

  // ---------------- report ----------------
  initial begin : report
    int guard;
    guard = 0;
    while (!(g_lat[0].done_i && g_lat[1].done_i && g_lat[2].done_i) && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    check("all_instances_done", 0,
          32'(g_lat[0].done_i && g_lat[1].done_i && g_lat[2].done_i), 32'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
